// File: rtl/aes_core_scheduler_pkg.sv
// rtl/aes_core_scheduler_pkg.sv - shared types, states and defaults for the AES core scheduler
package aes_core_scheduler_pkg;

  localparam int DEFAULT_NUM_REQ = 2;
  localparam int KEY_W           = 256;
  localparam int BLK_W           = 128;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY_LOAD,
    KEY_WAIT,
    RUN,
    CORE_WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, searching from the requester after last_grant
module rr_arbiter
  import aes_core_scheduler_pkg::*;
#(
  parameter int N   = DEFAULT_NUM_REQ,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_grant_i,
  output logic [N-1:0]   grant_o
);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDW'((int'(last_grant_i) + off) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// rtl/aes_core_scheduler.sv - shares one AES-256 core among requesters, caching the last expanded key
module aes_core_scheduler
  import aes_core_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 resetH,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_decrypt,
  input  key_t [NUM_REQ-1:0]   req_key,
  input  blk_t [NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output blk_t                 rsp_data,
  output logic                 core_key_load,
  output key_t                 core_key,
  input  logic                 core_key_done,
  output logic                 core_start,
  output logic                 core_decrypt,
  output blk_t                 core_din,
  input  logic                 core_done,
  input  blk_t                 core_dout,
  output logic [CNT_W-1:0]     key_reloads
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e           state_q, state_d;
  key_t             key_q, key_d;
  blk_t             din_q, din_d;
  logic             dec_q, dec_d;
  logic [IDW-1:0]   id_q, id_d;
  key_t             cached_key_q, cached_key_d;
  logic             key_valid_q, key_valid_d;
  logic [CNT_W-1:0] key_reloads_q, key_reloads_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  blk_t             rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     win_id;
  logic               key_hit;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_id = IDW'(i);
      end
    end
  end

  // A job may skip key expansion only when the full 256-bit key matches the cached one.
  assign key_hit = key_valid_q && (req_key[win_id] == cached_key_q);

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q       <= IDLE;
      key_q         <= '0;
      din_q         <= '0;
      dec_q         <= 1'b0;
      id_q          <= '0;
      cached_key_q  <= '0;
      key_valid_q   <= 1'b0;
      key_reloads_q <= '0;
      last_grant_q  <= IDW'(NUM_REQ - 1);
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      din_q         <= din_d;
      dec_q         <= dec_d;
      id_q          <= id_d;
      cached_key_q  <= cached_key_d;
      key_valid_q   <= key_valid_d;
      key_reloads_q <= key_reloads_d;
      last_grant_q  <= last_grant_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    din_d         = din_q;
    dec_d         = dec_q;
    id_d          = id_q;
    cached_key_d  = cached_key_q;
    key_valid_d   = key_valid_q;
    key_reloads_d = key_reloads_q;
    last_grant_d  = last_grant_q;
    rsp_data_d    = rsp_data_q;
    req_ready     = '0;
    rsp_valid     = '0;
    core_key_load = 1'b0;
    core_start    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is masked during reset so every output reads zero immediately.
        if (!resetH) begin
          req_ready = grant;
        end
        if (|grant) begin
          key_d   = req_key[win_id];
          din_d   = req_data[win_id];
          dec_d   = req_decrypt[win_id];
          id_d    = win_id;
          state_d = key_hit ? RUN : KEY_LOAD;
        end
      end

      KEY_LOAD: begin
        core_key_load = 1'b1;
        state_d       = KEY_WAIT;
      end

      KEY_WAIT: begin
        if (core_key_done) begin
          cached_key_d = key_q;
          key_valid_d  = 1'b1;
          if (key_reloads_q != '1) begin
            key_reloads_d = key_reloads_q + 1'b1;
          end
          state_d = RUN;
        end
      end

      RUN: begin
        core_start = 1'b1;
        state_d    = CORE_WAIT;
      end

      CORE_WAIT: begin
        if (core_done) begin
          rsp_data_d = core_dout;
          state_d    = RESP;
        end
      end

      RESP: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign core_key     = key_q;
  assign core_din     = din_q;
  assign core_decrypt = dec_q;
  assign rsp_data     = rsp_data_q;
  assign key_reloads  = key_reloads_q;

endmodule
